onc_run_monitor: RTL

- Synthesisable run controller and monitor that sits beside the ONC-16 core, on the same imem/dmem buses the bench drives.
- Gates a program run, counts cycles and data-memory writes, and captures the value written to a configurable result address.
- Detects program completion (PC parked in a self-loop) or a cycle-budget timeout, and reports either through status outputs.
- Replaces fixed-delay `$finish` runs with an exact completion signal for benches and for FPGA bring-up.

---
 rtl/onc_run_monitor_pkg.sv | 20 ++
 rtl/onc_run_monitor_if.sv | 13 +
 rtl/onc_run_monitor_sat_counter.sv | 30 +++
 rtl/onc_run_monitor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/onc_run_monitor_pkg.sv
// Shared constants for the ONC-16 run monitor: FSM encoding and default budgets.
`ifndef ONC_PKG_SV
`define ONC_PKG_SV
package onc_pkg;

  localparam int unsigned ONC_DATA_W = 16;
  localparam int unsigned ONC_INST_W = 16;

  localparam int unsigned DEF_HALT_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

endpackage
`endif

// File: rtl/onc_run_monitor_if.sv
// Core-side imem/dmem observation bus; the core (or bench) drives, the monitor listens.
interface onc_run_monitor_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_dout;
  logic              dmem_we;

  modport master (output imem_addr, output dmem_addr, output dmem_dout, output dmem_we);
  modport slave  (input  imem_addr, input  dmem_addr, input  dmem_dout, input  dmem_we);
endinterface

// File: rtl/onc_run_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over enable.
module onc_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/onc_run_monitor.sv
// Run controller beside the ONC-16 core: gates the run, counts cycles/stores,
// captures the result word and flags halt (PC self-loop) or budget timeout.
module onc_run_monitor
  import onc_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 16,
  parameter int unsigned        DATA_W         = ONC_DATA_W,
  parameter int unsigned        CNT_W          = 32,
  parameter int unsigned        HALT_CYCLES    = DEF_HALT_CYCLES,
  parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [ADDR_W-1:0]  RESULT_ADDR    = ADDR_W'(16'h00FF)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 clear,
  onc_run_monitor_if.slave     bus,
  output logic                 cpu_n_rst,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     write_count,
  output logic [ADDR_W-1:0]    halt_pc,
  output logic [DATA_W-1:0]    result_data,
  output logic                 result_valid
);

  run_state_e        state_d, state_q;
  logic [ADDR_W-1:0] prev_addr_d, prev_addr_q;
  logic [ADDR_W-1:0] halt_pc_d, halt_pc_q;
  logic [DATA_W-1:0] result_data_d, result_data_q;
  logic              result_valid_d, result_valid_q;
  logic              cpu_n_rst_d, cpu_n_rst_q;
  logic              running_d, running_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;

  logic              run_clear, cyc_en, wr_en, same_en, same_clr;
  logic              same_addr, halt_hit, tmo_hit;
  logic [CNT_W-1:0]  same_cnt;

  onc_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clock(clock), .n_rst(n_rst), .enable(cyc_en), .clear(run_clear), .count(cycle_count)
  );

  onc_sat_counter #(.WIDTH(CNT_W)) u_write_cnt (
    .clock(clock), .n_rst(n_rst), .enable(wr_en), .clear(run_clear), .count(write_count)
  );

  onc_sat_counter #(.WIDTH(CNT_W)) u_same_cnt (
    .clock(clock), .n_rst(n_rst), .enable(same_en), .clear(same_clr), .count(same_cnt)
  );

  // Halt beats timeout when both land on the same edge.
  assign same_addr = (bus.imem_addr == prev_addr_q);
  assign halt_hit  = (state_q == ST_RUN) && same_addr &&
                     (same_cnt == CNT_W'(HALT_CYCLES - 2));
  assign tmo_hit   = (state_q == ST_RUN) && !halt_hit &&
                     (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    prev_addr_d    = prev_addr_q;
    halt_pc_d      = halt_pc_q;
    result_data_d  = result_data_q;
    result_valid_d = result_valid_q;
    run_clear      = 1'b0;
    cyc_en         = 1'b0;
    wr_en          = 1'b0;
    same_en        = 1'b0;
    same_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        prev_addr_d = bus.imem_addr;
        if (start) begin
          run_clear      = 1'b1;
          same_clr       = 1'b1;
          result_valid_d = 1'b0;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_en      = 1'b1;
        prev_addr_d = bus.imem_addr;
        wr_en       = bus.dmem_we;
        if (bus.dmem_we && (bus.dmem_addr == RESULT_ADDR)) begin
          result_data_d  = bus.dmem_dout;
          result_valid_d = 1'b1;
        end
        same_en  = same_addr;
        same_clr = !same_addr;
        if (halt_hit) begin
          state_d   = ST_HALTED;
          halt_pc_d = bus.imem_addr;
        end else if (tmo_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_HALTED, ST_TIMEOUT: begin
        if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_n_rst_d = (state_d != ST_IDLE);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_HALTED);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      prev_addr_q    <= '0;
      halt_pc_q      <= '0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      cpu_n_rst_q    <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_addr_q    <= prev_addr_d;
      halt_pc_q      <= halt_pc_d;
      result_data_q  <= result_data_d;
      result_valid_q <= result_valid_d;
      cpu_n_rst_q    <= cpu_n_rst_d;
      running_q      <= running_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
    end
  end

  assign cpu_n_rst    = cpu_n_rst_q;
  assign running      = running_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign halt_pc      = halt_pc_q;
  assign result_data  = result_data_q;
  assign result_valid = result_valid_q;

endmodule
